// File: rtl/tdm_pkg.sv
// Shared constants and types for the eight-slot TDM demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tdm_pkg;

   localparam int NSLOTS    = 8;
   localparam int SLOT_W    = 3;
   // Consecutive blocked cycles tolerated on the final beat before the frame is dropped.
   localparam int STALL_MAX = 16;
   localparam int STALL_W   = $clog2(STALL_MAX + 1);

   typedef enum logic {HUNT, RUN} tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux: clear-to-0, load-to-1, increment with 7->0 wrap.
// Latency: registered, new index visible the cycle after the control pulse.
// Backpressure: none; advances only when the parent pulses a control input.
// Ports: clr/load1/inc controls (clr wins, then load1), slot index out, last = slot is 7.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load1,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot,
   output logic              last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SLOT_W'(1);
      end else if (inc) begin
         // Natural 3-bit overflow gives the 7->0 wrap.
         slot <= slot + 1'b1;
      end
   end

   assign last = (slot == SLOT_W'(NSLOTS - 1));

endmodule

// File: rtl/tdm_demux8.sv
// Eight-slot TDM demultiplexer: framed serial words in, completed frame out as eight parallel words.
// Latency: frame_valid and y0..y7 update the cycle after the slot-7 beat is accepted; 8-cycle min frame period.
// Backpressure: only the slot-7 beat can stall (held frame not taken); >16 stalled cycles drops the frame and sets overrun.
// Ports: in_valid/in_ready/in_sync/in_data beat input; frame_valid/frame_ready/y0..y7 frame output;
//        slot = next in-sync slot index; sync_err = one-cycle framing error pulse; overrun = sticky drop flag.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sync,
   input  logic [W-1:0]      in_data,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic [W-1:0]      y0,
   output logic [W-1:0]      y1,
   output logic [W-1:0]      y2,
   output logic [W-1:0]      y3,
   output logic [W-1:0]      y4,
   output logic [W-1:0]      y5,
   output logic [W-1:0]      y6,
   output logic [W-1:0]      y7,
   output logic [SLOT_W-1:0] slot,
   output logic              sync_err,
   output logic              overrun
);

   tdm_state_t          state;
   logic [STALL_W-1:0]  stall_cnt;
   logic [W-1:0]        shadow [0:NSLOTS-2];
   logic [W-1:0]        yreg   [0:NSLOTS-1];

   logic last;
   logic accept, stalled, stall_trip;
   logic wr_slot0, wr_mid, complete, err;
   logic ctr_clr, ctr_load1, ctr_inc;
   logic go_run, go_hunt;

   // Only the final beat waits, and only while the previous frame is still unread.
   // Depends on registered state and frame_ready only, never on in_valid.
   assign in_ready   = !((state == RUN) && last && frame_valid && !frame_ready);
   assign accept     = in_valid && in_ready;
   assign stalled    = in_valid && !in_ready;
   assign stall_trip = stalled && (stall_cnt == STALL_W'(STALL_MAX));

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clr),
      .load1 (ctr_load1),
      .inc   (ctr_inc),
      .slot  (slot),
      .last  (last)
   );

   // Beat decode. stall_trip and accept are mutually exclusive since stalling implies !in_ready.
   always_comb begin
      wr_slot0  = 1'b0;
      wr_mid    = 1'b0;
      complete  = 1'b0;
      err       = 1'b0;
      ctr_clr   = 1'b0;
      ctr_load1 = 1'b0;
      ctr_inc   = 1'b0;
      go_run    = 1'b0;
      go_hunt   = 1'b0;
      if (stall_trip) begin
         ctr_clr = 1'b1;
         go_hunt = 1'b1;
      end else if (accept) begin
         if (state == HUNT) begin
            if (in_sync) begin
               wr_slot0  = 1'b1;
               ctr_load1 = 1'b1;
               go_run    = 1'b1;
            end
         end else if (in_sync) begin
            // A sync mid-frame abandons the partial frame and restarts at slot 0.
            wr_slot0  = 1'b1;
            ctr_load1 = 1'b1;
            err       = (slot != '0);
         end else if (slot == '0) begin
            err     = 1'b1;
            ctr_clr = 1'b1;
            go_hunt = 1'b1;
         end else begin
            ctr_inc = 1'b1;
            if (last) begin
               complete = 1'b1;
            end else begin
               wr_mid = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         sync_err  <= 1'b0;
         overrun   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         sync_err <= err;
         if (stall_trip) begin
            overrun <= 1'b1;
         end
         if (go_hunt) begin
            state <= HUNT;
         end else if (go_run) begin
            state <= RUN;
         end
         if (stalled && !stall_trip) begin
            stall_cnt <= stall_cnt + 1'b1;
         end else begin
            stall_cnt <= '0;
         end
      end
   end

   // Shadow holds slots 0..6; the slot-7 beat goes straight to the output register.
   always_ff @(posedge clk) begin
      if (wr_slot0) begin
         shadow[0] <= in_data;
      end else if (wr_mid) begin
         shadow[slot] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_valid <= 1'b0;
         for (int i = 0; i < NSLOTS; i++) begin
            yreg[i] <= '0;
         end
      end else if (complete) begin
         // in_ready gating guarantees the register is free (or being read) here.
         for (int i = 0; i < NSLOTS - 1; i++) begin
            yreg[i] <= shadow[i];
         end
         yreg[NSLOTS-1] <= in_data;
         frame_valid    <= 1'b1;
      end else if (frame_ready) begin
         frame_valid <= 1'b0;
      end
   end

   assign y0 = yreg[0];
   assign y1 = yreg[1];
   assign y2 = yreg[2];
   assign y3 = yreg[3];
   assign y4 = yreg[4];
   assign y5 = yreg[5];
   assign y6 = yreg[6];
   assign y7 = yreg[7];

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Eight-slot time-division demultiplexer: the receive-side counterpart of the 8:1 selector. A framed stream of words arrives on one channel, with `in_sync` marking slot 0. The block steers each word into one of eight slot registers and presents a completed frame as eight parallel words under a valid/ready handshake. It sits between a serial/TDM link front end and per-channel consumers.

## Interface
Parameters:
- `W`, 8, data width per slot.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_sync`  in  1  qualifies the beat as slot 0; sampled only with `in_valid`.
- `in_data`  in  W  slot word.
- `frame_valid`  out  1  completed frame held on `y0`..`y7`.
- `frame_ready`  in  1  consumer accepts the frame.
- `y0`..`y7`  out  W each  slot 0..7 words of the held frame.
- `slot`  out  3  slot index the next accepted in-sync beat fills.
- `sync_err`  out  1  one-cycle pulse on a framing error.
- `overrun`  out  1  sticky; set when a frame is dropped; cleared only by reset.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- FSM state HUNT:
  - accepted beats without `in_sync` are discarded;
  - a beat with `in_sync` writes shadow slot 0, sets `slot`=1 and moves to RUN.
- FSM state RUN, for an accepted beat:
  - `slot`=0 with `in_sync`: write shadow slot 0; `slot`=1.
  - `slot`=0 without `in_sync`: pulse `sync_err`, discard the beat, go to HUNT.
  - `slot`≠0 without `in_sync`: write shadow[`slot`]; `slot`+1, wrapping 7→0.
  - `slot`≠0 with `in_sync`: pulse `sync_err`, abandon the partial frame, write the beat as shadow slot 0, `slot`=1, stay in RUN.
- Frame completion (accepted beat at `slot`=7):
  - if the output register is free (`!frame_valid || frame_ready`), shadow slots 0–6 plus the current beat load into `y0`..`y7` and `frame_valid` sets;
  - this cannot fail because of `in_ready` gating, below.
- `in_ready` = !(RUN && `slot`==7 && `frame_valid` && !`frame_ready`).
  - Backpressure applies only to the final beat of a frame; all other beats are always accepted.
  - There is no combinational path from `in_valid` to `in_ready`.
- `overrun` sets if `in_valid` is held low-ready for more than 16 consecutive cycles at `slot`=7. The block then drops the shadow frame, returns to HUNT and resets `slot` to 0.
- `frame_valid` clears on `frame_ready` unless a new frame loads in the same cycle.
- Shadow contents are not required to be cleared on errors.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM to HUNT;
  - `slot`=0, `frame_valid`=0, `y0`..`y7`=0, `sync_err`=0, `overrun`=0;
  - `in_ready`=1 (combinational from reset state);
  - the stall counter is cleared.
- Latency: the slot-7 beat accepted at edge N gives `frame_valid`=1 and valid `y*` after edge N. Minimum frame period is 8 cycles.
- Full throughput: back-to-back frames with `frame_ready` tied high give no stalls.
- `sync_err` is registered and high for exactly the cycle after the offending beat.
- Simultaneous completion and accept: the old frame is consumed and the new one loaded in the same edge, so `frame_valid` stays high.
- Reset mid-frame discards all state. The first post-reset frame requires `in_sync`.

## Structure
- Package `tdm_pkg`:
  - `NSLOTS`=8;
  - `SLOT_W`=3;
  - `STALL_MAX`=16;
  - `typedef enum logic {HUNT, RUN} tdm_state_t`.
- Sub-module `tdm_slot_ctr`: slot counter with load-to-1 and clear-to-0, plus wrap detect (`last` = slot==7).
- Top contains the FSM, the shadow array (7×W), the output register (8×W), the stall counter and the handshake logic.
- Target size: 150–250 lines.

## Test plan
- Clean frames: sync on 0x10, then 0x11..0x17 with `frame_ready`=1 → `y0`..`y7`=0x10..0x17 one cycle after the last beat; second frame 0x20..0x27 follows with no stall; `sync_err`=0.
- HUNT discard: 3 beats without sync, then a sync frame 0xA0..0xA7 → only the A-frame is output; `sync_err` never pulses.
- Early sync: sync, 0x01, 0x02, then sync at slot 3 with 0x30, then 0x31..0x37 → `sync_err` pulse once; output frame is 0x30..0x37.
- Missing sync: a full frame, then a non-sync beat at slot 0 → `sync_err` pulse; FSM in HUNT; `slot`=0; no frame output.
- Backpressure: `frame_ready`=0 with a frame held; send the next frame → `in_ready`=0 only at slot 7. Raise `frame_ready` after 5 cycles → old frame taken, new frame loaded the same edge, `frame_valid` stays 1. Hold `frame_ready`=0 for 17 cycles instead → `overrun`=1, FSM in HUNT.
- Reset mid-frame: `rst_n` low after 4 beats, asynchronously → outputs zero immediately. After release, a sync frame 0x50..0x57 completes correctly.
